accel_spi_sequencer: RTL and testbench
======================================

# accel_spi_sequencer

Hardware sequencer for the ADXL345 accelerometer on the 3-wire SPI pins (CS_N, SCLK, bidirectional SDAT). It configures the sensor after reset and then burst-reads X/Y/Z whenever DATA_READY (INT1) is high or a poll timer expires. It presents the sign-extended 16-bit samples to the Nios fabric with a one-cycle valid strobe, so software never bit-bangs the sensor. It sits between the top-level accelerometer pins and a PIO/Avalon register wrapper.

## Interface
- CLK_DIV, 25, SCLK half-period in clk cycles (1 MHz SCLK at 50 MHz); legal range 2..255
- STARTUP_CYCLES, 100000, wait after reset before the first transaction (2 ms at 50 MHz)
- POLL_PERIOD, 0, cycles between forced reads when INT is silent; 0 disables polling
- clk_clk  in  1  system clock; all logic on its rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- g_sensor_int  in  1  ADXL345 INT1, asynchronous; passes through a 2-FF synchronizer
- range_sel  in  2  g-range code, sampled once at start of init
- spi_cs_n  out  1  chip select; reset 1
- spi_sclk  out  1  SPI clock, mode 3 (idle high); reset 1
- sdat_o  out  1  SDAT drive value; reset 0
- sdat_oe  out  1  SDAT output enable (tristate at top level); reset 0
- sdat_i  in  1  SDAT pin input
- accel_x, accel_y, accel_z  out  16 each  latest sample, two's complement; reset 0
- sample_valid  out  1  one-cycle pulse when accel_* update; reset 0
- init_done  out  1  high once configuration completes; reset 0
- busy  out  1  high while spi_cs_n is low; reset 0

## Operation
- FSM states: STARTUP → INIT_WR → INIT_GAP → (repeat ×5) → IDLE → READ → READ_GAP → IDLE.
- STARTUP: counts STARTUP_CYCLES, then loads write 0.
- Init writes, in order (address, data):
  - 0x31 DATA_FORMAT = 0x48 | range_sel (SPI 3-wire, FULL_RES)
  - 0x2C BW_RATE = 0x0A
  - 0x2F INT_MAP = 0x00
  - 0x2E INT_ENABLE = 0x80
  - 0x2D POWER_CTL = 0x08
- Each write is 16 bits: command {R=0, MB=0, addr[5:0]} followed by the data byte, MSB first.
- init_done rises on the cycle after the fifth write's CS_N goes high and stays high until reset.
- Read trigger, evaluated in IDLE only:
  - synchronized INT == 1, or
  - poll counter reaches POLL_PERIOD (when nonzero).
  - If both occur in the same cycle, exactly one read starts.
  - The poll counter clears when each read starts.
- Read transaction: 56 bits. Command 0xF2 ({R=1, MB=1, 0x32}), then 6 data bytes DATAX0, X1, Y0, Y1, Z0, Z1.
  - accel_x = {X1, X0}, likewise for Y and Z.
- Readback registers update together with the sample_valid pulse. accel_* hold their value otherwise.
- INT staying high after a read starts a new read once the gap ends. INT edges during a read are ignored.

## Timing
- D = CLK_DIV, t0 = cycle in which spi_cs_n goes low, N = bit count (16 or 56).
- Bit k:
  - spi_sclk falls at t0 + D(1+2k); sdat_o updates in the same cycle.
  - spi_sclk rises at t0 + D(2+2k); sdat_i is registered in that cycle.
- spi_cs_n returns high at t0 + (2N+1)·D, so it is low for (2N+1)·D cycles: 33D for a write, 113D for a read.
- spi_sclk stays high whenever spi_cs_n is high.
- sdat_oe:
  - high from t0 through the end of a write, and through command bit 7 of a read;
  - drops at the falling SCLK edge of bit 8 of a read;
  - low whenever CS_N is high.
- Minimum CS_N-high gap between transactions: 2D cycles (INIT_GAP / READ_GAP).
- sample_valid and accel_* update: the cycle after CS_N rises, i.e. t0 + 113D + 1.
- busy equals !spi_cs_n, registered with it.
- Reset asserted mid-transaction: on the next edge all outputs take their reset values (CS_N=1, SCLK=1, oe=0). The FSM restarts at STARTUP, and no partial sample is published.
- Synchronizer latency: INT seen by the FSM 2 cycles after the pin rises. A read begins with CS_N low 1 cycle after that if IDLE and the gap has expired.

## Test plan
- Reset: hold reset_reset_n=0 for 5 cycles with random sdat_i → every output at its stated reset value. Release → no CS_N activity for STARTUP_CYCLES.
- Init (CLK_DIV=2, STARTUP_CYCLES=10, range_sel=2'b11) → SPI slave model captures exactly 0x31/0x4B, 0x2C/0x0A, 0x2F/0x00, 0x2E/0x80, 0x2D/0x08. Each CS_N low for 66 cycles, gaps ≥4 cycles, then init_done=1.
- INT read: model returns bytes 0x34,0x12,0xFE,0xFF,0x00,0x80 → accel_x=0x1234, accel_y=0xFFFE, accel_z=0x8000. sample_valid is one pulse, 227 cycles after CS_N falls; sdat_oe drops at bit 8.
- INT held high for 3 reads → three back-to-back transactions separated by exactly 2D cycles of CS_N high, three sample_valid pulses.
- Polling (POLL_PERIOD=1000, INT tied 0) → reads start every 1000 cycles after init. INT and poll expiry in the same cycle → one read only.
- Reset asserted at bit 30 of a read → CS_N=1 the next cycle, accel_* return to 0, no sample_valid; full init repeats after release.

Source files
------------

// File: rtl/accel_spi_sequencer.sv
// ADXL345 3-wire SPI sequencer: configures the sensor after reset, then
// burst-reads X/Y/Z on data-ready or poll timeout and publishes the samples
// with a single-cycle valid strobe.
module accel_spi_sequencer #(
  parameter int CLK_DIV        = 25,
  parameter int STARTUP_CYCLES = 100000,
  parameter int POLL_PERIOD    = 0
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        g_sensor_int,
  input  logic [1:0]  range_sel,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        sdat_o,
  output logic        sdat_oe,
  input  logic        sdat_i,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy
);

  localparam logic [2:0] ST_STARTUP  = 3'd0;
  localparam logic [2:0] ST_INIT_WR  = 3'd1;
  localparam logic [2:0] ST_INIT_GAP = 3'd2;
  localparam logic [2:0] ST_IDLE     = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_READ_GAP = 3'd5;

  localparam logic [31:0] DIV_LIM   = 32'(CLK_DIV - 1);
  localparam logic [31:0] GAP_LIM1  = 32'(2 * CLK_DIV - 1);
  localparam logic [31:0] GAP_LIM2  = 32'(2 * CLK_DIV - 2);
  localparam logic [31:0] START_LIM = 32'(STARTUP_CYCLES);
  localparam logic [31:0] POLL_LIM  = 32'(POLL_PERIOD - 1);

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [7:0]  half;
  logic [7:0]  last_half;
  logic [2:0]  wr_idx;
  logic [1:0]  range_q;
  logic [55:0] tx;
  logic [47:0] rx;
  logic [31:0] poll_cnt;
  logic        int_meta;
  logic        int_sync;
  logic        read_trigger;

  // Configuration word (command byte, data byte) for each init write.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [1:0] rng);
    case (idx)
      3'd0:    init_word = {8'h31, 6'b010010, rng};
      3'd1:    init_word = 16'h2C0A;
      3'd2:    init_word = 16'h2F00;
      3'd3:    init_word = 16'h2E80;
      default: init_word = 16'h2D08;
    endcase
  endfunction

  assign last_half    = (state == ST_READ) ? 8'd112 : 8'd32;
  assign read_trigger = int_sync || ((POLL_PERIOD != 0) && (poll_cnt >= POLL_LIM));

  // Two-flop synchronizer for the asynchronous INT1 pin.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      int_meta <= g_sensor_int;
      int_sync <= int_meta;
    end
  end

  // Sequencer FSM, SPI bit engine and sample publication.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state        <= ST_STARTUP;
      cnt          <= '0;
      half         <= '0;
      wr_idx       <= '0;
      range_q      <= '0;
      tx           <= '0;
      rx           <= '0;
      poll_cnt     <= '0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b1;
      sdat_o       <= 1'b0;
      sdat_oe      <= 1'b0;
      busy         <= 1'b0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!init_done)
        poll_cnt <= '0;
      else if (poll_cnt != '1)
        poll_cnt <= poll_cnt + 32'd1;

      case (state)
        ST_STARTUP: begin
          if (cnt >= START_LIM) begin
            range_q  <= range_sel;
            tx       <= {init_word(3'd0, range_sel), 40'd0};
            wr_idx   <= 3'd0;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            sdat_oe  <= 1'b1;
            cnt      <= '0;
            half     <= '0;
            state    <= ST_INIT_WR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_INIT_WR, ST_READ: begin
          if (cnt == DIV_LIM) begin
            cnt  <= '0;
            half <= half + 8'd1;
            if (half == last_half) begin
              spi_cs_n <= 1'b1;
              busy     <= 1'b0;
              sdat_oe  <= 1'b0;
              sdat_o   <= 1'b0;
              state    <= (state == ST_READ) ? ST_READ_GAP : ST_INIT_GAP;
            end else if (!half[0]) begin
              spi_sclk <= 1'b0;
              sdat_o   <= tx[55];
              tx       <= {tx[54:0], 1'b0};
              if ((state == ST_READ) && (half == 8'd16))
                sdat_oe <= 1'b0;
            end else begin
              spi_sclk <= 1'b1;
              rx       <= {rx[46:0], sdat_i};
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_INIT_GAP: begin
          if (wr_idx == 3'd4) begin
            if (cnt == '0)
              init_done <= 1'b1;
            if (cnt == GAP_LIM2) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else if (cnt == GAP_LIM1) begin
            tx       <= {init_word(wr_idx + 3'd1, range_q), 40'd0};
            wr_idx   <= wr_idx + 3'd1;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            sdat_oe  <= 1'b1;
            cnt      <= '0;
            half     <= '0;
            state    <= ST_INIT_WR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_IDLE: begin
          if (read_trigger) begin
            tx       <= {8'hF2, 48'd0};
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            sdat_oe  <= 1'b1;
            cnt      <= '0;
            half     <= '0;
            poll_cnt <= '0;
            state    <= ST_READ;
          end
        end

        ST_READ_GAP: begin
          if (cnt == '0) begin
            accel_x      <= {rx[39:32], rx[47:40]};
            accel_y      <= {rx[23:16], rx[31:24]};
            accel_z      <= {rx[7:0],   rx[15:8]};
            sample_valid <= 1'b1;
          end
          if (cnt == GAP_LIM2) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          state <= ST_STARTUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Self-checking bench for accel_spi_sequencer with a behavioural ADXL345
// 3-wire SPI slave, table-driven init/read vectors and multi-cycle sequences.
module tb_accel_spi_sequencer;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        int_pin;
  logic [1:0]  range_sel;
  logic        spi_cs_n, spi_sclk, sdat_o, sdat_oe, sdat_i;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          bits;
    logic [55:0] data;
    int          low_len;
    int          gap_before;
    int          t_end;
    logic        oe7;
    logic        oe8;
  } frame_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } init_vec_t;

  typedef struct {
    logic [47:0] resp;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } read_vec_t;

  frame_t      frames[$];
  init_vec_t   init_tab[5];
  read_vec_t   rd_tab[3];
  logic [47:0] resp = '0;

  logic mon_en = 1'b0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_init = 1'b0, is_read = 1'b0;
  logic oe7 = 1'b0, oe8 = 1'b0;
  logic [55:0] shift = '0;
  int fall_cnt = 0, rise_cnt = 0, t_fall = 0, t_rise_last = 0, cur_gap = 0;
  int fall_events = 0, last_fall_cyc = 0, sv_count = 0, sv_cyc = 0;
  int init_rise_cyc = 0, idle_bad = 0, busy_bad = 0;

  accel_spi_sequencer #(
    .CLK_DIV(D),
    .STARTUP_CYCLES(10),
    .POLL_PERIOD(1000)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(reset_n),
    .g_sensor_int(int_pin),
    .range_sel(range_sel),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .sdat_o(sdat_o),
    .sdat_oe(sdat_oe),
    .sdat_i(sdat_i),
    .accel_x(accel_x),
    .accel_y(accel_y),
    .accel_z(accel_z),
    .sample_valid(sample_valid),
    .init_done(init_done),
    .busy(busy)
  );

  // Free-running clock and edge counter used for all timing measurements.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave model and bus monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_cs && !spi_cs_n) begin
        t_fall = cyc; cur_gap = cyc - t_rise_last; last_fall_cyc = cyc;
        fall_cnt = 0; rise_cnt = 0; shift = '0; is_read = 1'b0;
        oe7 = 1'b0; oe8 = 1'b0; fall_events++;
      end
      if (!spi_cs_n) begin
        if (prev_sclk && !spi_sclk) begin
          if (fall_cnt == 7) oe7 = sdat_oe;
          if (fall_cnt == 8) oe8 = sdat_oe;
          if (is_read && fall_cnt >= 8 && fall_cnt < 56) sdat_i = resp[47 - (fall_cnt - 8)];
          fall_cnt++;
        end
        if (!prev_sclk && spi_sclk) begin
          shift = {shift[54:0], sdat_o};
          rise_cnt++;
          if (rise_cnt == 8) is_read = shift[7];
        end
      end
      if (!prev_cs && spi_cs_n) begin
        frames.push_back('{rise_cnt, shift, cyc - t_fall, cur_gap, cyc, oe7, oe8});
        t_rise_last = cyc;
      end
      if (spi_cs_n && (spi_sclk !== 1'b1 || sdat_oe !== 1'b0)) idle_bad++;
      if (busy !== ~spi_cs_n) busy_bad++;
      if (sample_valid) begin sv_count++; sv_cyc = cyc; end
      if (init_done && !prev_init) init_rise_cyc = cyc;
      prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_init = init_done;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timeout waiting got 0 expected 1", name);
  endtask

  task automatic waitFalls(input int target, input int bound, input string name);
    int n = 0;
    while (fall_events < target && n < bound) begin tick(); n++; end
    if (fall_events < target) timeoutFail(name);
  endtask

  task automatic waitSamples(input int target, input int bound, input string name);
    int n = 0;
    while (sv_count < target && n < bound) begin tick(); n++; end
    if (sv_count < target) timeoutFail(name);
  endtask

  task automatic waitInit(input int bound, input string name);
    int n = 0;
    while (init_done !== 1'b1 && n < bound) begin tick(); n++; end
    if (init_done !== 1'b1) timeoutFail(name);
  endtask

  task automatic checkInitFrames(input string tag);
    checkOutput({tag, "_frame_count"}, 64'(frames.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < frames.size()) begin
        checkOutput($sformatf("%s_wr%0d_word", tag, i), 64'(frames[i].data[15:0]),
                    64'({init_tab[i].addr, init_tab[i].data}));
        checkOutput($sformatf("%s_wr%0d_bits", tag, i), 64'(frames[i].bits), 64'd16);
        checkOutput($sformatf("%s_wr%0d_low", tag, i), 64'(frames[i].low_len), 64'(33 * D));
        if (i > 0)
          checkOutput($sformatf("%s_wr%0d_gap_ok", tag, i), 64'(frames[i].gap_before >= 2 * D), 64'd1);
      end
    end
    if (frames.size() >= 5)
      checkOutput({tag, "_init_done_time"}, 64'(init_rise_cyc), 64'(frames[4].t_end + 1));
  endtask

  task automatic applyStimulus(input read_vec_t v, output int t_set, output int t_cs);
    int base = fall_events;
    resp = v.resp;
    t_set = cyc;
    int_pin = 1'b1;
    waitFalls(base + 1, 50, "int_read_start");
    t_cs = last_fall_cyc;
    int_pin = 1'b0;
  endtask

  initial begin
    int t_set, t_cs, ta, tb, tc, td, sv_base, f_base;
    logic quiet;

    init_tab[0] = '{8'h31, 8'h4B};
    init_tab[1] = '{8'h2C, 8'h0A};
    init_tab[2] = '{8'h2F, 8'h00};
    init_tab[3] = '{8'h2E, 8'h80};
    init_tab[4] = '{8'h2D, 8'h08};
    rd_tab[0] = '{48'h3412FEFF0080, 16'h1234, 16'hFFFE, 16'h8000};
    rd_tab[1] = '{48'hFF7F010080FF, 16'h7FFF, 16'h0001, 16'hFF80};
    rd_tab[2] = '{48'h000055AACDAB, 16'h0000, 16'hAA55, 16'hABCD};

    reset_n = 1'b0; int_pin = 1'b0; range_sel = 2'b11; sdat_i = 1'b0;
    repeat (5) begin tick(); sdat_i = 1'($urandom_range(0, 1)); end
    checkOutput("rst_cs_n", 64'(spi_cs_n), 64'd1);
    checkOutput("rst_sclk", 64'(spi_sclk), 64'd1);
    checkOutput("rst_sdat_o", 64'(sdat_o), 64'd0);
    checkOutput("rst_sdat_oe", 64'(sdat_oe), 64'd0);
    checkOutput("rst_accel", {16'd0, accel_x, accel_y, accel_z}, 64'd0);
    checkOutput("rst_flags", 64'({sample_valid, init_done, busy}), 64'd0);

    mon_en = 1'b1;
    reset_n = 1'b1;
    quiet = 1'b1;
    repeat (10) begin tick(); if (spi_cs_n !== 1'b1) quiet = 1'b0; end
    checkOutput("startup_quiet", 64'(quiet), 64'd1);
    tick();
    checkOutput("startup_first_cs", 64'(spi_cs_n), 64'd0);

    waitInit(1000, "init_done_wait");
    checkInitFrames("init");
    repeat (10) tick();

    $display("[TB] table-driven INT reads");
    for (int i = 0; i < 3; i++) begin
      sv_base = sv_count;
      applyStimulus(rd_tab[i], t_set, t_cs);
      checkOutput($sformatf("rd%0d_int_latency", i), 64'(t_cs - t_set), 64'd3);
      waitSamples(sv_base + 1, 400, "rd_sample_wait");
      checkOutput($sformatf("rd%0d_accel_x", i), 64'(accel_x), 64'(rd_tab[i].x));
      checkOutput($sformatf("rd%0d_accel_y", i), 64'(accel_y), 64'(rd_tab[i].y));
      checkOutput($sformatf("rd%0d_accel_z", i), 64'(accel_z), 64'(rd_tab[i].z));
      checkOutput($sformatf("rd%0d_sv_delay", i), 64'(sv_cyc - last_fall_cyc), 64'(113 * D + 1));
      if (frames.size() > 0) begin
        checkOutput($sformatf("rd%0d_low", i), 64'(frames[$].low_len), 64'(113 * D));
        checkOutput($sformatf("rd%0d_oe_bits7_8", i), 64'({frames[$].oe7, frames[$].oe8}), 64'b10);
        checkOutput($sformatf("rd%0d_cmd", i), 64'(frames[$].data[55:48]), 64'hF2);
      end
      tick();
      checkOutput($sformatf("rd%0d_sv_width", i), 64'(sample_valid), 64'd0);
      repeat (20) tick();
    end

    $display("[TB] INT held for three reads");
    frames.delete();
    f_base = fall_events; sv_base = sv_count;
    resp = rd_tab[0].resp;
    int_pin = 1'b1;
    waitFalls(f_base + 3, 1200, "held_three_starts");
    int_pin = 1'b0;
    waitSamples(sv_base + 3, 600, "held_three_samples");
    repeat (10) tick();
    checkOutput("held_frames", 64'(frames.size()), 64'd3);
    if (frames.size() >= 3) begin
      checkOutput("held_gap1", 64'(frames[1].gap_before), 64'(2 * D));
      checkOutput("held_gap2", 64'(frames[2].gap_before), 64'(2 * D));
    end
    checkOutput("held_sv_pulses", 64'(sv_count - sv_base), 64'd3);

    $display("[TB] polling");
    f_base = fall_events;
    waitFalls(f_base + 1, 1500, "poll_first");
    ta = last_fall_cyc;
    waitFalls(f_base + 2, 1500, "poll_second");
    tb = last_fall_cyc;
    checkOutput("poll_period", 64'(tb - ta), 64'd1000);
    begin
      int n = 0;
      while (cyc < tb + 997 && n < 1100) begin tick(); n++; end
    end
    int_pin = 1'b1;
    tick();
    int_pin = 1'b0;
    waitFalls(f_base + 3, 100, "coincide_start");
    tc = last_fall_cyc;
    sv_base = sv_count;
    checkOutput("coincide_time", 64'(tc - tb), 64'd1000);
    waitFalls(f_base + 4, 1500, "coincide_next");
    td = last_fall_cyc;
    checkOutput("coincide_single_read", 64'(td - tc), 64'd1000);
    checkOutput("coincide_sv_pulses", 64'(sv_count - sv_base), 64'd1);

    $display("[TB] reset during read");
    f_base = fall_events;
    waitFalls(f_base + 1, 1500, "abort_read_start");
    begin
      int n = 0;
      while (fall_cnt < 31 && n < 200) begin tick(); n++; end
    end
    checkOutput("abort_pre_accel_x", 64'(accel_x != 16'd0), 64'd1);
    sv_base = sv_count;
    reset_n = 1'b0;
    tick();
    checkOutput("abort_cs_n", 64'(spi_cs_n), 64'd1);
    checkOutput("abort_sclk_oe", 64'({spi_sclk, sdat_oe}), 64'b10);
    checkOutput("abort_accel", {16'd0, accel_x, accel_y, accel_z}, 64'd0);
    checkOutput("abort_flags", 64'({sample_valid, init_done, busy}), 64'd0);
    repeat (4) tick();
    frames.delete();
    reset_n = 1'b1;
    waitInit(1000, "reinit_wait");
    checkInitFrames("reinit");
    checkOutput("abort_no_sample", 64'(sv_count - sv_base), 64'd0);
    checkOutput("idle_bus_state", 64'(idle_bad), 64'd0);
    checkOutput("busy_tracks_cs", 64'(busy_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
